// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and press strobe.
// Optional auto-repeat strobes on a held key when KEYPAD_REPEAT_EN is defined.
//
// Ports:
//   clk        in   system clock (1000 Hz)
//   rst_n      in   asynchronous active-low reset
//   cols_n[3:0] in  column lines, active-low, asynchronous to clk
//   rows_n[3:0] out row drive, one-hot active-low
//   key[4:0]   out  debounced key code, 31 when no key is accepted
//   key_strobe out  one-cycle pulse on each accepted press (and repeat)

module keypad_scanner #(
    parameter int ROW_CYCLES     = 4,
    parameter int DEBOUNCE_SCANS = 2
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY_SCANS = 32,
    parameter int REPEAT_RATE_SCANS  = 8
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cols_n,
    output logic [3:0] rows_n,
    output logic [4:0] key,
    output logic       key_strobe
);

    localparam logic [4:0] T_NULL = 5'd31;
    localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        CHANGE_CHK
    } state_t;

    // Matrix position to key code.
    function automatic logic [4:0] key_code(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [4:0] k;
        case ({r, c})
            4'h0:    k = 5'd1;
            4'h1:    k = 5'd2;
            4'h2:    k = 5'd3;
            4'h3:    k = 5'd10;
            4'h4:    k = 5'd4;
            4'h5:    k = 5'd5;
            4'h6:    k = 5'd6;
            4'h7:    k = 5'd11;
            4'h8:    k = 5'd7;
            4'h9:    k = 5'd8;
            4'hA:    k = 5'd9;
            4'hB:    k = 5'd12;
            4'hC:    k = 5'd14;
            4'hD:    k = 5'd0;
            4'hE:    k = 5'd15;
            default: k = 5'd13;
        endcase
        return k;
    endfunction

    // Column synchronizer
    logic [3:0] cols_s1;
    logic [3:0] cols_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cols_s1 <= 4'hF;
            cols_s2 <= 4'hF;
        end else begin
            cols_s1 <= cols_n;
            cols_s2 <= cols_s1;
        end
    end

    // Row sequencer
    logic [CW-1:0] cyc_cnt;
    logic [1:0]    row_idx;
    logic          sample;
    logic          scan_done;

    assign sample    = (cyc_cnt == CW'(ROW_CYCLES - 1));
    assign scan_done = sample && (row_idx == 2'd3);
    assign rows_n    = ~(4'b0001 << row_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            row_idx <= 2'd0;
        end else if (sample) begin
            cyc_cnt <= '0;
            row_idx <= row_idx + 2'd1;
        end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
        end
    end

    // Low bits in the current row; lowest column index wins.
    logic [2:0] row_lows;
    logic [1:0] row_first;

    always_comb begin
        row_lows  = 3'd0;
        row_first = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!cols_s2[c]) begin
                row_lows  = row_lows + 3'd1;
                row_first = c[1:0];
            end
        end
    end

    // Per-scan accumulator. The count saturates at 2: anything
    // above one low bit already means "no single key".
    logic [1:0] acc_cnt;
    logic [4:0] acc_code;
    logic [2:0] tot;
    logic [4:0] row_code;
    logic [4:0] scan_result;

    assign row_code = key_code(row_idx, row_first);
    assign tot      = {1'b0, acc_cnt} + row_lows;

    always_comb begin
        scan_result = T_NULL;
        if (tot == 3'd1) begin
            scan_result = (acc_cnt == 2'd0) ? row_code : acc_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt  <= 2'd0;
            acc_code <= T_NULL;
        end else if (scan_done) begin
            acc_cnt  <= 2'd0;
            acc_code <= T_NULL;
        end else if (sample) begin
            acc_cnt <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
            if (acc_cnt == 2'd0 && row_lows != 3'd0) begin
                acc_code <= row_code;
            end
        end
    end

    // Debounce FSM
    state_t        state_q, state_d;
    logic [4:0]    cand_q, cand_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cnt_inc;
    logic [4:0]    key_q, key_d;
    logic          strobe_q, strobe_d;
    logic          cnt_full;

    assign cnt_inc  = cnt_q + DW'(1);
    assign cnt_full = (cnt_inc == DW'(DEBOUNCE_SCANS));

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY_SCANS + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic [RW-1:0] rep_inc;
    assign rep_inc = rep_q + RW'(1);
`endif

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        strobe_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d    = rep_q;
`endif
        if (scan_done) begin
            unique case (state_q)
                IDLE: begin
                    if (scan_result != T_NULL) begin
                        cand_d  = scan_result;
                        cnt_d   = DW'(1);
                        state_d = PRESS_CHK;
                    end
                end
                PRESS_CHK: begin
                    if (scan_result == cand_q) begin
                        if (cnt_full) begin
                            key_d    = cand_q;
                            strobe_d = 1'b1;
                            state_d  = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d    = '0;
`endif
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (scan_result == T_NULL) begin
                        state_d = IDLE;
                    end else begin
                        cand_d = scan_result;
                        cnt_d  = DW'(1);
                    end
                end
                HELD: begin
                    if (scan_result != key_q) begin
                        cand_d  = scan_result;
                        cnt_d   = DW'(1);
                        state_d = CHANGE_CHK;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = '0;
                    end else if (rep_inc ==
                                 RW'(REPEAT_DELAY_SCANS)) begin
                        // Rewind so the next repeat lands one
                        // rate period later.
                        strobe_d = 1'b1;
                        rep_d    = RW'(REPEAT_DELAY_SCANS -
                                       REPEAT_RATE_SCANS);
                    end else begin
                        rep_d = rep_inc;
`endif
                    end
                end
                CHANGE_CHK: begin
                    if (scan_result == cand_q) begin
                        if (!cnt_full) begin
                            cnt_d = cnt_inc;
                        end else if (cand_q == T_NULL) begin
                            key_d   = T_NULL;
                            state_d = IDLE;
                        end else begin
                            key_d    = cand_q;
                            strobe_d = 1'b1;
                            state_d  = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d    = '0;
`endif
                        end
                    end else if (scan_result == key_q) begin
                        state_d = HELD;
                    end else begin
                        cand_d = scan_result;
                        cnt_d  = DW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cand_q   <= T_NULL;
            cnt_q    <= '0;
            key_q    <= T_NULL;
            strobe_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            strobe_q <= strobe_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end

    assign key        = key_q;
    assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a keypad
// matrix model and a strobe scoreboard.

module tb_keypad_scanner;

    localparam logic [4:0] T_NULL = 5'd31;

    logic       clk;
    logic       rst_n;
    logic [3:0] cols_n;
    logic [3:0] rows_n;
    logic [4:0] key;
    logic       key_strobe;

    // pressed[r*4+c] = key at row r, column c is down
    logic [15:0] pressed;

    int errors = 0;
    int checks = 0;

    logic [4:0] exp_q[$];
    logic       prev_strobe = 1'b0;

    keypad_scanner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cols_n     (cols_n),
        .rows_n     (rows_n),
        .key        (key),
        .key_strobe (key_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cols_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !rows_n[r]) begin
                    cols_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected code.
    always @(negedge clk) begin
        if (rst_n && key_strobe) begin
            chk("strobe_gap", 32'(prev_strobe), 32'd0);
            chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                chk("strobe_key", 32'(key), 32'(exp_q.pop_front()));
            end
        end
        prev_strobe = key_strobe;
    end

    // Wait for the start of a scan (row0 just became active).
    task automatic align();
        logic [3:0] prev;
        bit         hit;
        prev = rows_n;
        hit  = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            @(negedge clk);
            if (rows_n == 4'b1110 && prev == 4'b0111) hit = 1'b1;
            prev = rows_n;
        end
        chk("align", 32'(hit), 32'd1);
    endtask

    task automatic wait_key(input string tag,
                            input logic [4:0] exp,
                            input int lo,
                            input int hi,
                            input bit no_null);
        int n;
        bit seen;
        bit nulled;
        n      = 0;
        seen   = 1'b0;
        nulled = 1'b0;
        while (!seen && n < hi + 16) begin
            @(negedge clk);
            n++;
            if (key === T_NULL) nulled = 1'b1;
            if (key === exp) seen = 1'b1;
        end
        chk({tag, "_key"}, 32'(key), 32'(exp));
        chk({tag, "_latency_in_range"},
            32'(n >= lo && n <= hi), 32'd1);
        if (no_null) chk({tag, "_never_null"}, 32'(nulled), 32'd0);
    endtask

    task automatic check_rows(input string tag);
        logic [3:0] e;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            e = ~(4'b0001 << ((i / 4) % 4));
            chk(tag, 32'(rows_n), 32'(e));
        end
    endtask

    initial begin
        bit bad;

        // Reset
        rst_n   = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        chk("rst_rows", 32'(rows_n), 32'(4'b1110));
        chk("rst_key", 32'(key), 32'(T_NULL));
        chk("rst_strobe", 32'(key_strobe), 32'd0);
        rst_n = 1'b1;
        check_rows("rows_seq");

        // Press and release '5'
        exp_q.push_back(5'd5);
        align();
        pressed[1*4+1] = 1'b1;
        wait_key("press5", 5'd5, 32, 51, 1'b0);
        repeat (40) @(negedge clk);
        chk("hold5", 32'(key), 32'd5);
        align();
        pressed = '0;
        wait_key("rel5", T_NULL, 32, 51, 1'b0);
        chk("q_after_5", 32'(exp_q.size()), 32'd0);

        // Bouncing '#', then held
        align();
        repeat (6) @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            pressed[3*4+2] = ((k / 6) % 2) == 0;
            @(negedge clk);
        end
        pressed[3*4+2] = 1'b1;
        chk("bounce_no_key", 32'(key), 32'(T_NULL));
        exp_q.push_back(5'd15);
        wait_key("bounce", 5'd15, 1, 40, 1'b0);
        align();
        pressed = '0;
        wait_key("rel_hash", T_NULL, 32, 51, 1'b0);
        chk("q_after_hash", 32'(exp_q.size()), 32'd0);

        // '1' and '9' together, then release '9'
        align();
        pressed[0*4+0] = 1'b1;
        pressed[2*4+2] = 1'b1;
        repeat (64) @(negedge clk);
        chk("two_keys_null", 32'(key), 32'(T_NULL));
        exp_q.push_back(5'd1);
        align();
        pressed[2*4+2] = 1'b0;
        wait_key("one_left", 5'd1, 32, 51, 1'b0);
        align();
        pressed = '0;
        wait_key("rel1", T_NULL, 32, 51, 1'b0);
        chk("q_after_two", 32'(exp_q.size()), 32'd0);

        // Slide 'A' -> 'B'
        exp_q.push_back(5'd10);
        align();
        pressed[0*4+3] = 1'b1;
        wait_key("press_a", 5'd10, 32, 51, 1'b0);
        exp_q.push_back(5'd11);
        align();
        pressed = '0;
        pressed[1*4+3] = 1'b1;
        wait_key("slide_b", 5'd11, 32, 51, 1'b1);
        align();
        pressed = '0;
        wait_key("rel_b", T_NULL, 32, 51, 1'b0);
        chk("q_after_slide", 32'(exp_q.size()), 32'd0);

        // Hold 'D' for 60 scans
        exp_q.push_back(5'd13);
`ifdef KEYPAD_REPEAT_EN
        repeat (4) exp_q.push_back(5'd13);
`endif
        align();
        pressed[3*4+3] = 1'b1;
        wait_key("press_d", 5'd13, 32, 51, 1'b0);
        bad = 1'b0;
        repeat (60 * 16 - 32) begin
            @(negedge clk);
            if (key !== 5'd13) bad = 1'b1;
        end
        chk("hold_d_stable", 32'(bad), 32'd0);
        align();
        pressed = '0;
        wait_key("rel_d", T_NULL, 32, 51, 1'b0);
        chk("q_after_d", 32'(exp_q.size()), 32'd0);

        // Reset while a key is held
        exp_q.push_back(5'd0);
        align();
        pressed[3*4+1] = 1'b1;
        wait_key("press0", 5'd0, 32, 51, 1'b0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_key", 32'(key), 32'(T_NULL));
        chk("mid_rst_rows", 32'(rows_n), 32'(4'b1110));
        chk("mid_rst_strobe", 32'(key_strobe), 32'd0);
        pressed = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_rows("rows_after_rst");
        repeat (80) @(negedge clk);
        chk("after_rst_key", 32'(key), 32'(T_NULL));
        chk("q_final", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
